// File: rtl/pcpi_pkg.sv
// pcpi_pkg: shared state encoding, frame sizes and status bit positions for the PCPI byte bridge
package pcpi_pkg;
    typedef enum logic [1:0] {LOAD, ISSUE, DRAIN} state_t;
    localparam logic [3:0] FRAME_IN_BYTES  = 4'd12;
    localparam logic [2:0] FRAME_OUT_BYTES = 3'd5;
    localparam int STAT_WR      = 0;
    localparam int STAT_TIMEOUT = 1;
endpackage

// File: rtl/pcpi_byte_shift.sv
// pcpi_byte_shift: 32-bit little-endian load/shift register presenting the next byte at o_byte
module pcpi_byte_shift (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_shift,
    input  logic [31:0] i_data,
    output logic [7:0]  o_byte
);
    logic [31:0] r_q;
    always_ff @(posedge clk) begin
        if (rst) r_q <= '0;
        else if (i_load) r_q <= i_data;
        else if (i_shift) r_q <= {8'h00, r_q[31:8]};
    end
    assign o_byte = r_q[7:0];
endmodule

// File: rtl/pcpi_byte_bridge.sv
// pcpi_byte_bridge: serial byte frames in, PCPI instruction issue, serial status+result bytes out
module pcpi_byte_bridge
    import pcpi_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        pcpi_valid,
    output logic [31:0] pcpi_insn,
    output logic [31:0] pcpi_rs1,
    output logic [31:0] pcpi_rs2,
    input  logic        pcpi_wr,
    input  logic [31:0] pcpi_rd,
    input  logic        pcpi_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready
);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
    state_t      r_state;
    logic [3:0]  r_icnt;
    logic [2:0]  r_ocnt;
    logic [7:0]  r_tcnt;
    logic [95:0] r_frame;
    logic [7:0]  r_out_data;
    logic        r_out_valid;
    logic        w_in_xfer, w_out_xfer, w_done, w_to;
    logic [7:0]  w_status, w_byte;
    assign in_ready   = r_state == LOAD;
    assign pcpi_valid = r_state == ISSUE;
    assign pcpi_insn  = r_frame[31:0];
    assign pcpi_rs1   = r_frame[63:32];
    assign pcpi_rs2   = r_frame[95:64];
    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;
    assign w_in_xfer  = in_valid & in_ready;
    assign w_out_xfer = r_out_valid & out_ready;
    assign w_done     = pcpi_valid & pcpi_ready;
    // ready on the final cycle beats the timeout
    assign w_to       = pcpi_valid & ~pcpi_ready & (r_tcnt == TO_LAST);
    always_comb begin
        w_status = '0;
        w_status[STAT_WR] = w_done & pcpi_wr;
        w_status[STAT_TIMEOUT] = w_to;
    end
    pcpi_byte_shift u_shift (
        .clk(clk),
        .rst(rst),
        .i_load(w_done | w_to),
        .i_shift(w_out_xfer),
        .i_data(w_done ? pcpi_rd : 32'h0),
        .o_byte(w_byte)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= LOAD;
            r_icnt      <= '0;
            r_ocnt      <= '0;
            r_tcnt      <= '0;
            r_frame     <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            unique case (r_state)
                LOAD: if (w_in_xfer) begin
                    r_frame <= {in_data, r_frame[95:8]};
                    r_icnt  <= (r_icnt == FRAME_IN_BYTES - 4'd1) ? 4'd0 : r_icnt + 4'd1;
                    r_tcnt  <= '0;
                    if (r_icnt == FRAME_IN_BYTES - 4'd1) r_state <= ISSUE;
                end
                ISSUE: begin
                    r_tcnt <= r_tcnt + 8'd1;
                    if (w_done | w_to) begin
                        r_state     <= DRAIN;
                        r_out_data  <= w_status;
                        r_out_valid <= 1'b1;
                        r_ocnt      <= '0;
                    end
                end
                DRAIN: if (w_out_xfer) begin
                    if (r_ocnt == FRAME_OUT_BYTES - 3'd1) begin
                        r_state     <= LOAD;
                        r_out_valid <= 1'b0;
                        r_out_data  <= '0;
                        r_ocnt      <= '0;
                    end else begin
                        r_out_data <= w_byte;
                        r_ocnt     <= r_ocnt + 3'd1;
                    end
                end
                default: r_state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_pcpi_byte_bridge.sv
// tb_pcpi_byte_bridge: directed frames with a cycle-counting coprocessor model and byte-stream checks
module tb_pcpi_byte_bridge;
    localparam int TO = 16;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        pcpi_valid;
    logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2;
    logic        pcpi_wr = 1'b0;
    logic [31:0] pcpi_rd = '0;
    logic        pcpi_ready = 1'b0;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    int          n_checks = 0;
    int          n_errors = 0;
    pcpi_byte_bridge #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn), .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
        .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd), .pcpi_ready(pcpi_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit ok = 0;
        if (gaps) repeat ($urandom_range(0, 2)) tick();
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 50 && !ok; i++) begin
            ok = in_ready;
            tick();
        end
        in_valid = 1'b0;
        if (!ok) check("in_ready_wait", 32'd0, 32'd1);
    endtask
    task automatic send_frame(input logic [31:0] insn, rs1, rs2, input bit gaps);
        logic [95:0] f;
        f = {rs2, rs1, insn};
        for (int k = 0; k < 12; k++) send_byte(f[8*k +: 8], gaps);
    endtask
    task automatic run_cop(input int resp, input logic wr, input logic [31:0] rd,
                           input logic [31:0] insn, rs1, rs2, input int exp_cnt);
        int vc = 0;
        bit fin = 0;
        pcpi_ready = 1'b0;
        for (int i = 0; i < 300 && !fin; i++) begin
            if (pcpi_valid) begin
                vc++;
                check("in_ready_issue", 32'(in_ready), 32'd0);
                check("insn", pcpi_insn, insn);
                check("rs1", pcpi_rs1, rs1);
                check("rs2", pcpi_rs2, rs2);
                if (vc == resp) begin
                    pcpi_ready = 1'b1;
                    pcpi_wr    = wr;
                    pcpi_rd    = rd;
                end
                tick();
                pcpi_ready = 1'b0;
                pcpi_rd    = 32'hFFFF_FFFF;
            end else if (vc > 0) fin = 1;
            else tick();
        end
        if (!fin) check("issue_end_wait", 32'd0, 32'd1);
        check("valid_cycles", 32'(vc), 32'(exp_cnt));
    endtask
    task automatic recv(input logic [39:0] exp, input int stall_at);
        logic [7:0] e;
        bit ok;
        for (int k = 0; k < 5; k++) begin
            e  = exp[39 - 8*k -: 8];
            ok = 0;
            for (int i = 0; i < 50 && !ok; i++) if (out_valid) ok = 1; else tick();
            if (!ok) check("out_valid_wait", 32'd0, 32'd1);
            check("in_ready_drain", 32'(in_ready), 32'd0);
            if (k == stall_at) begin
                out_ready = 1'b0;
                for (int s = 0; s < 10; s++) begin
                    tick();
                    check("stall_data", {24'd0, out_data}, {24'd0, e});
                end
            end
            check("out_byte", {24'd0, out_data}, {24'd0, e});
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        check("in_ready_after", 32'(in_ready), 32'd1);
        check("out_valid_after", 32'(out_valid), 32'd0);
    endtask
    task automatic frame(input logic [31:0] insn, rs1, rs2, input int resp, input logic wr,
                         input logic [31:0] rd, input int exp_cnt, input logic [39:0] exp,
                         input bit gaps, input int stall_at);
        send_frame(insn, rs1, rs2, gaps);
        run_cop(resp, wr, rd, insn, rs1, rs2, exp_cnt);
        recv(exp, stall_at);
    endtask
    initial begin
        tick();
        tick();
        rst = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_pcpi_valid", 32'(pcpi_valid), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", {24'd0, out_data}, 32'd0);
        check("rst_insn", pcpi_insn, 32'd0);
        // stray ready while loading must be ignored
        pcpi_ready = 1'b1;
        pcpi_rd    = 32'hDEAD_DEAD;
        frame(32'h02B50533, 32'h7, 32'h6, 4, 1'b1, 32'h2A, 4, 40'h01_2A_00_00_00, 0, -1);
        frame(32'h00000013, 32'h1, 32'h2, 0, 1'b1, 32'hFFFF_FFFF, TO, 40'h02_00_00_00_00, 0, -1);
        frame(32'h00000033, 32'h3, 32'h4, TO, 1'b0, 32'h12345678, TO, 40'h00_78_56_34_12, 0, -1);
        frame(32'hDEADBEEF, 32'h01020304, 32'hA5A55A5A, 2, 1'b1, 32'hCAFEF00D, 2,
              40'h01_0D_F0_FE_CA, 1, 2);
        for (int k = 0; k < 7; k++) send_byte(8'hE0 + 8'(k), 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_insn", pcpi_insn, 32'd0);
        check("mid_rst_rs1", pcpi_rs1, 32'd0);
        frame(32'h11223344, 32'h55667788, 32'h99AABBCC, 1, 1'b1, 32'h1, 1, 40'h01_01_00_00_00, 0, -1);
        frame(32'h0000000B, 32'h10, 32'h20, 3, 1'b1, 32'h30, 3, 40'h01_30_00_00_00, 0, -1);
        frame(32'h0000002B, 32'h100, 32'h200, 5, 1'b0, 32'hABCD, 5, 40'h00_CD_AB_00_00, 0, -1);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
